// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - parametrised valid/ready stage register with 2-entry skid buffer
// Backpressure is registered: o_ready depends only on held state and i_stall.
module pipe_skid_reg #(
  parameter int DATA_W              = 32,
  parameter int CTRL_W              = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [1:0]        o_count
);

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [1:0]        count_q, count_d;
  logic              in_fire, out_fire;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      count_q     <= count_d;
    end
  end

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (i_flush) begin
      // A beat accepted this cycle is dropped; one delivered this cycle already left.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end else if (in_fire) begin
            state_d     = S_TWO;
            skid_data_d = i_data;
            skid_ctrl_d = i_ctrl;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      S_ONE:   count_d = 2'd1;
      S_TWO:   count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_comb begin
    o_valid = (state_q != S_EMPTY);
    o_ready = (state_q != S_TWO) & ~i_stall;
    o_data  = main_data_q;
    o_ctrl  = main_ctrl_q;
    o_count = count_q;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and random scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst, valid, ready, stall, flush;
  logic [31:0] data;
  logic [7:0]  ctrl;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [7:0]  o_ctrl;
  logic [1:0]  o_count;

  int checks = 0;
  int errors = 0;

  logic [39:0] q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data = '0;

  pipe_skid_reg dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (o_ready),
    .i_data  (data),
    .i_ctrl  (ctrl),
    .o_valid (o_valid),
    .i_ready (ready),
    .o_data  (o_data),
    .o_ctrl  (o_ctrl),
    .i_stall (stall),
    .i_flush (flush),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge against the model, then advance the model across the next posedge.
  task automatic tick();
    logic ev, er;
    @(negedge clk);
    ev = (q.size() != 0);
    er = (q.size() < 2) && !stall;
    chk("o_valid", 64'(o_valid), 64'(ev));
    chk("o_ready", 64'(o_ready), 64'(er));
    chk("o_count", 64'(o_count), 64'(q.size()));
    if (ev) begin
      chk("o_data", 64'(o_data), 64'(q[0][31:0]));
      chk("o_ctrl", 64'(o_ctrl), 64'(q[0][39:32]));
    end
    if (hold_prev) chk("hold_data", 64'(o_data), 64'(prev_data));
    hold_prev = ev && !ready && rst && !flush;
    prev_data = o_data;
    if (!rst || flush) begin
      q.delete();
    end else begin
      if (ev && ready) void'(q.pop_front());
      if (valid && er) q.push_back({ctrl, data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; ready = 1'b0; stall = 1'b0; flush = 1'b0;
    data = '0; ctrl = '0;
    @(posedge clk);
    #1;
    tick();
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_ctrl", 64'(o_ctrl), 64'h0);
    rst = 1'b1;
    tick();

    // streaming
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; data = 32'h100 + 32'(i); ctrl = 8'(i);
      tick();
    end
    valid = 1'b0;
    tick(); tick();

    // backpressure
    ready = 1'b0; valid = 1'b1; data = 32'hA; ctrl = 8'h1A;
    tick();
    data = 32'hB; ctrl = 8'h1B;
    tick();
    valid = 1'b0;
    tick();
    ready = 1'b1;
    tick(); tick(); tick();

    // stall
    ready = 1'b0; valid = 1'b1; data = 32'h5; ctrl = 8'h05;
    tick();
    stall = 1'b1; ready = 1'b1; data = 32'h6; ctrl = 8'h06;
    tick(); tick();
    stall = 1'b0;
    tick();
    valid = 1'b0;
    tick(); tick();

    // flush with two beats held and a concurrent input beat
    ready = 1'b0; valid = 1'b1; data = 32'h11; ctrl = 8'hFF;
    tick();
    data = 32'h22; ctrl = 8'h3C;
    tick();
    flush = 1'b1; data = 32'h33; ctrl = 8'h77;
    tick();
    flush = 1'b0; valid = 1'b0;
    chk("flush_data", 64'(o_data), 64'h11);
    chk("flush_ctrl", 64'(o_ctrl), 64'h0);
    chk("flush_cnt", 64'(o_count), 64'h0);
    ready = 1'b1;
    tick(); tick();

    // reset beats flush with two beats held
    ready = 1'b0; valid = 1'b1; data = 32'h44; ctrl = 8'h44;
    tick();
    data = 32'h55; ctrl = 8'h55;
    tick();
    rst = 1'b0; flush = 1'b1; valid = 1'b0;
    tick();
    chk("rp_valid", 64'(o_valid), 64'h0);
    chk("rp_data", 64'(o_data), 64'h0);
    chk("rp_ctrl", 64'(o_ctrl), 64'h0);
    chk("rp_count", 64'(o_count), 64'h0);
    chk("rp_ready", 64'(o_ready), 64'h1);
    rst = 1'b1; flush = 1'b0;
    tick();

    // random handshake
    for (int i = 0; i < 10000; i++) begin
      valid = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 4) == 0);
      data  = $urandom;
      ctrl  = 8'($urandom);
      tick();
    end
    valid = 1'b0; stall = 1'b0; ready = 1'b1;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field stage registers, such as the one between MEM and WB.
- One instance carries a whole stage payload, split into DATA_W data bits and CTRL_W control bits, through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput while keeping backpressure registered: there is no combinational path from i_ready to o_ready.
- Stall and flush hooks from the hazard unit are kept, with defined priority against the handshake.

Parameters:
- DATA_W, 32: width of datapath payload (pc, alu result, lsu data, rd addr packed by the instantiating stage).
- CTRL_W, 8: width of control payload (wren, wb_sel and similar); cleared on flush.
- CLEAR_DATA_ON_FLUSH, 0: 1 = data payload is also zeroed on flush; 0 = data is held, so only control and valid are killed.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous active-low reset.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat.
- i_data  in  DATA_W  upstream data payload.
- i_ctrl  in  CTRL_W  upstream control payload.
- o_valid  out  1  downstream beat valid.
- i_ready  in  1  downstream accepts a beat.
- o_data  out  DATA_W  downstream data payload.
- o_ctrl  out  CTRL_W  downstream control payload.
- i_stall  in  1  hazard stall: blocks acceptance.
- i_flush  in  1  hazard flush: kills all held beats.
- o_count  out  2  held beats (0..2), for debug and perf counters.

Behaviour:
- Storage:
  - main register (drives o_data/o_ctrl) plus skid register, each with a valid bit.
  - States: EMPTY (count 0), ONE (main valid), TWO (main and skid valid).
- Handshake:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
  - o_valid = (state != EMPTY).
  - o_ready = (state != TWO) & ~i_stall, a function of state and i_stall only.
  - When o_valid=1 and i_ready=0, o_data/o_ctrl must not change until out_fire.
- Latency: 1 cycle from in_fire into EMPTY to o_valid=1 with that payload. In steady state (i_ready=1, i_valid=1, no stall) throughput is 1 beat/cycle.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in.
    - in_fire & ~out_fire -> TWO, skid<=in.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO: o_ready=0 so no in_fire.
    - out_fire -> ONE, main<=skid, skid valid cleared.
    - otherwise hold.
- Ordering: beats leave in arrival order; no beat is dropped or duplicated.
- Stall:
  - i_stall=1 only deasserts o_ready; held beats still drain to downstream.
  - Stall and flush together: flush wins.
- Flush:
  - i_flush=1 at a clock edge -> next state EMPTY.
  - Both valid bits cleared; main and skid ctrl fields zeroed.
  - Data fields zeroed only if CLEAR_DATA_ON_FLUSH=1.
  - Any in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as delivered, since downstream sampled it.
- Reset:
  - i_rst=0 at a clock edge -> EMPTY, with all registers zero (data, ctrl, valid).
  - Resulting outputs: o_valid=0, o_ctrl=0, o_data=0, o_count=0.
  - o_ready follows its equation, i.e. 1 unless i_stall.
  - Reset overrides flush and any handshake, including a reset asserted mid-burst with TWO beats held.
- o_count: registered; equals 0/1/2 for EMPTY/ONE/TWO.

Test Plan:
- Streaming: reset, then i_valid=1 with data 0x100..0x10F, i_ready=1 -> o_valid rises the cycle after the first beat; 16 beats out in order, one per cycle; o_count stays 1.
- Backpressure: ONE holding 0xA, i_ready=0, push 0xB -> state TWO, o_ready=0, o_data stays 0xA; i_ready=1 -> 0xA then 0xB, o_count 2->1->0.
- Stall: ONE holding 0x5, i_stall=1, i_valid=1 with 0x6, i_ready=1 -> o_ready=0, 0x5 delivered, 0x6 not accepted, o_count=0; release stall -> 0x6 accepted.
- Flush in TWO: main ctrl 0xFF, data 0x11; skid ctrl 0x3C; i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_count=0, o_ctrl=0; o_data=0x11 (default parameter) or 0 with CLEAR_DATA_ON_FLUSH=1; the concurrent input beat never appears.
- Reset priority: TWO held, i_rst=0 and i_flush=1 together -> next cycle all outputs 0, o_ready=1 (i_stall=0).
- Randomised handshake: random i_valid, i_ready, i_stall, 10k cycles -> scoreboard matches in-order, o_count matches the model, o_data stable while o_valid & ~i_ready.
